// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 16:1 mux.
// One grant at a time, released on done, withdrawal or hold-time limit.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [15:0]         req,
  input  logic                done,
  output logic [3:0]          sel,
  output logic [15:0]         gnt,
  output logic                gnt_valid,
  output logic                timeout
);

  localparam int unsigned N     = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic [2*N-1:0]     w_req_dbl;
  logic [N-1:0]       w_req_rot;
  logic [SEL_W-1:0]   w_off;
  logic [SEL_W-1:0]   w_winner;
  logic               w_any;
  logic               w_hold_lim;
  logic               w_withdraw;
  logic               w_release;
  logic               w_timeout;

  // Rotate req so bit 0 is the pointer position, then take the lowest set bit.
  assign w_req_dbl = {req, req};
  assign w_req_rot = N'(w_req_dbl >> r_ptr);
  assign w_any     = |req;

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_off = SEL_W'(i);
      end
    end
  end

  assign w_winner = r_ptr + w_off;

  // Release causes; timeout only when the hold limit is the sole reason.
  assign w_hold_lim = (r_cnt == CNT_W'(HOLD_MAX - 1));
  assign w_withdraw = ~req[sel];
  assign w_release  = done | w_withdraw | w_hold_lim;
  assign w_timeout  = ~done & ~w_withdraw & w_hold_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      sel       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          gnt       <= '0;
          gnt_valid <= 1'b0;
          if (en && w_any) begin
            sel       <= w_winner;
            gnt       <= N'(1) << w_winner;
            gnt_valid <= 1'b1;
            r_cnt     <= '0;
            r_state   <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            // sel is held so the mux output does not glitch to input 0
            gnt       <= '0;
            gnt_valid <= 1'b0;
            r_ptr     <= sel + SEL_W'(1);
            timeout   <= w_timeout;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16-input mux (4-bit select, 16-bit data) among 16 requesters.
- Drives the mux select with the registered index of the current grant holder and a matching one-hot grant.
- Includes a per-grant hold-time limit so that one requester cannot monopolise the mux.
- Sits between the requester bank and the 16x1 mux select input.

Parameters:
- HOLD_MAX, 8, maximum cycles a grant is held before forced release (legal range 1..255).
- CNT_W, 8, width of the hold counter (must satisfy 2^CNT_W > HOLD_MAX).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; when low, no new grant is issued.
- req  input  16  request vector, one bit per mux data input.
- done  input  1  holder finished; release at the next edge.
- sel  output  4  mux select, the index of the current/last holder.
- gnt  output  16  one-hot grant; all zero when no holder.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, mid-grant included):
  - state=IDLE, sel=0, gnt=0, gnt_valid=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0, pick the first set bit scanning ptr, ptr+1, ... 15, 0, ... ptr-1 (wrap-around).
  - At the next edge: sel=winner, gnt=1<<winner, gnt_valid=1, counter=0, go to GRANT.
  - Latency from req to grant is one cycle.
  - If en=0 or req=0, stay in IDLE with outputs unchanged, except gnt=0 and gnt_valid=0.
- GRANT: the counter increments every cycle. Release when any of the following is true (evaluated on the current cycle):
  - (a) done=1;
  - (b) req[sel]=0, i.e. the requester withdrew;
  - (c) counter==HOLD_MAX-1.
- On release:
  - gnt=0, gnt_valid=0.
  - ptr=sel+1 mod 16 (15 wraps to 0).
  - Go to IDLE.
  - sel keeps its last value, so the mux output does not glitch to input 0.
  - timeout=1 for exactly one cycle, only when (c) is the sole cause (done=0 and req[sel]=1).
- Simultaneous release events: done has priority. If done and the limit coincide, timeout=0.
- Back-to-back requests: there is a minimum of one IDLE cycle between grants, so re-grant happens 2 cycles after release.
- en deasserted during GRANT does not revoke the grant. It only blocks the next grant.
- With HOLD_MAX=1, every grant lasts exactly one cycle; timeout pulses unless done=1 or the request drops.
- Requests arriving or changing during GRANT are sampled only in IDLE; there is no preemption.
- Fairness: with all 16 bits of req held high and no done, grants rotate 0, 1, ..., 15, 0. Each lasts HOLD_MAX cycles followed by 1 idle cycle.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt != 0 iff gnt_valid.
  - When gnt_valid=1, gnt[sel]=1.

Test Plan:
1. Reset then single request: rst_n low mid-run then high, req=16'h0010, en=1 -> one cycle later sel=4, gnt=16'h0010, gnt_valid=1. done pulse -> next edge gnt=0 with sel still 4; ptr=5.
2. Rotation with contention: req=16'hFFFF, done pulsed in the first cycle of each grant -> grant order 0, 1, 2, ..., 15, 0, with each grant separated by 1 idle cycle and timeout never asserted.
3. Timeout with HOLD_MAX=8: req=16'h0100 held and no done -> gnt_valid high for exactly 8 cycles, timeout=1 on the release cycle only, then re-grant to 8 two cycles later.
4. Wrap-around and priority: after a grant to 14 is released (ptr=15), req=16'h8001 -> grant 15. After that release, req=16'h8001 again -> grant 0.
5. Withdrawal, enable gating and simultaneous events:
   - req[sel] dropped during GRANT -> release next edge with timeout=0.
   - en=0 with req=16'h0003 -> no grant; raising en -> grant issued next cycle.
   - done and limit in the same cycle -> timeout=0.
6. Async reset mid-grant: rst_n asserted between clock edges while gnt=16'h0200 -> gnt=0, sel=0, gnt_valid=0 immediately, without waiting for a clock edge. After release of reset with req=16'h0200 -> grant to 9 (ptr restarted at 0).
